// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - control and status bundle for the quadrature decoder
interface quad_decoder_if #(
  parameter int N = 4
);
  logic         enable;
  logic         a_in;
  logic         b_in;
  logic         load;
  logic [N-1:0] data;
  logic         clr_err;
  logic [N-1:0] count;
  logic         dir;
  logic         step;
  logic         err;
  logic         err_sticky;

  modport master (
    output enable, a_in, b_in, load, data, clr_err,
    input  count, dir, step, err, err_sticky
  );

  modport slave (
    input  enable, a_in, b_in, load, data, clr_err,
    output count, dir, step, err, err_sticky
  );
endinterface

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - synchronised A/B quadrature decoder driving a loadable up/down position count
module quad_decoder #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  quad_decoder_if.slave   bus
);

  localparam int CW = $clog2(SYNC_STAGES + 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_init_cnt;
  logic [SYNC_STAGES-1:0] r_a_sync;
  logic [SYNC_STAGES-1:0] r_b_sync;
  logic [1:0]             r_prev;
  logic [N-1:0]           r_count;
  logic                   r_dir;
  logic                   r_step;
  logic                   r_err;
  logic                   r_err_sticky;

  logic [1:0] w_cur;
  logic [1:0] w_pos_cur;
  logic [1:0] w_pos_prev;
  logic [1:0] w_delta;

  assign w_cur = {r_a_sync[SYNC_STAGES-1], r_b_sync[SYNC_STAGES-1]};

  // Phase index along the up sequence 00,10,11,01: delta 1 = up, 3 = down, 2 = both bits flipped
  assign w_pos_cur  = {w_cur[0], w_cur[1] ^ w_cur[0]};
  assign w_pos_prev = {r_prev[0], r_prev[1] ^ r_prev[0]};
  assign w_delta    = w_pos_cur - w_pos_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_init_cnt   <= '0;
      r_a_sync     <= '0;
      r_b_sync     <= '0;
      r_prev       <= 2'b00;
      r_count      <= '0;
      r_dir        <= 1'b0;
      r_step       <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], bus.a_in};
      r_b_sync <= {r_b_sync[SYNC_STAGES-2:0], bus.b_in};
      r_prev   <= w_cur;
      r_step   <= 1'b0;
      r_err    <= 1'b0;

      if (bus.clr_err) r_err_sticky <= 1'b0;

      case (r_state)
        // Let the synchronisers flush the reset zeros so the idle level is never decoded
        S_INIT: begin
          if (r_init_cnt == CW'(SYNC_STAGES)) r_state <= S_RUN;
          else r_init_cnt <= r_init_cnt + CW'(1);
        end
        S_RUN: begin
          if (bus.enable) begin
            if (w_delta == 2'd2) begin
              r_err        <= 1'b1;
              r_err_sticky <= 1'b1;
            end else if (w_delta != 2'd0) begin
              r_dir <= (w_delta == 2'd1);
              if (!bus.load) begin
                r_step  <= 1'b1;
                r_count <= (w_delta == 2'd1) ? r_count + N'(1) : r_count - N'(1);
              end
            end
          end
        end
        default: r_state <= S_INIT;
      endcase

      if (bus.load) r_count <= bus.data;
    end
  end

  assign bus.count      = r_count;
  assign bus.dir        = r_dir;
  assign bus.step       = r_step;
  assign bus.err        = r_err;
  assign bus.err_sticky = r_err_sticky;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - self-checking bench for quad_decoder against a phase-sequence model
module tb_quad_decoder;

  logic clk;
  logic reset;

  quad_decoder_if #(.N(4)) bus ();

  quad_decoder #(.N(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (bus.step === 1'b1) step_cnt++;
    if (bus.err === 1'b1) err_cnt++;
    if (bus.step === 1'b1 && bus.err === 1'b1) both_cnt++;
  end

  int         m_count;
  bit         m_dir;
  bit         m_sticky;
  logic [1:0] m_ab;
  int         m_steps;
  int         m_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int phase_idx(input logic [1:0] ab);
    logic [1:0] seq [4];
    int idx;
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    idx = 0;
    for (int i = 0; i < 4; i++) if (seq[i] == ab) idx = i;
    return idx;
  endfunction

  function automatic logic [1:0] up_next(input logic [1:0] ab);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    return seq[(phase_idx(ab) + 1) % 4];
  endfunction

  function automatic logic [1:0] down_next(input logic [1:0] ab);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    return seq[(phase_idx(ab) + 3) % 4];
  endfunction

  // Model: classify a move by how far it advances along the up sequence
  task automatic model_move(input logic [1:0] ab, input bit en, input bit ld);
    int d;
    d = (phase_idx(ab) - phase_idx(m_ab) + 4) % 4;
    if (en) begin
      if (d == 2) begin
        m_errs++;
        m_sticky = 1;
      end else if (d != 0) begin
        m_dir = (d == 1);
        if (!ld) begin
          m_steps++;
          m_count = (d == 1) ? (m_count + 1) % 16 : (m_count + 15) % 16;
        end
      end
    end
    m_ab = ab;
  endtask

  task automatic apply(input logic [1:0] ab, input bit en);
    bus.enable = en;
    bus.a_in   = ab[1];
    bus.b_in   = ab[0];
    model_move(ab, en, 1'b0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"}, bus.count, m_count);
    chk({tag, "_dir"}, bus.dir, m_dir);
    chk({tag, "_steps"}, step_cnt, m_steps);
    chk({tag, "_errs"}, err_cnt, m_errs);
    chk({tag, "_sticky"}, bus.err_sticky, m_sticky);
  endtask

  int exp_down [6];
  int saved;
  logic [1:0] nab;
  int r;

  initial begin
    exp_down = '{3, 2, 1, 0, 15, 14};
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.a_in = 1'b1;
    bus.b_in = 1'b1;
    bus.load = 1'b0;
    bus.data = '0;
    bus.clr_err = 1'b0;
    m_count = 0; m_dir = 0; m_sticky = 0; m_ab = 2'b11; m_steps = 0; m_errs = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_dir", bus.dir, 0);
    chk("rst_step", bus.step, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_sticky", bus.err_sticky, 0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("idle_count", bus.count, 0);
    chk("idle_steps", step_cnt, 0);
    chk("idle_errs", err_cnt, 0);

    for (int i = 0; i < 20; i++) begin
      apply(up_next(m_ab), 1'b1);
      check_all("up");
    end
    chk("up_final_count", bus.count, 4);
    chk("up_final_dir", bus.dir, 1);
    chk("up_final_steps", step_cnt, 20);

    for (int i = 0; i < 6; i++) begin
      apply(down_next(m_ab), 1'b1);
      chk("down_seq", bus.count, exp_down[i]);
      check_all("down");
    end
    chk("down_final_dir", bus.dir, 0);

    // load lands on the same edge the up step is decoded
    nab = up_next(m_ab);
    bus.a_in = nab[1];
    bus.b_in = nab[0];
    model_move(nab, 1'b1, 1'b1);
    m_count = 6;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.load = 1'b1;
    bus.data = 4'd6;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    @(posedge clk);
    #1;
    check_all("load_collide");
    apply(up_next(m_ab), 1'b1);
    chk("load_next_count", bus.count, 7);
    check_all("load_next");

    while (m_ab != 2'b00) apply(up_next(m_ab), 1'b1);
    saved = m_count;
    apply(2'b11, 1'b1);
    chk("jump_count", bus.count, saved);
    check_all("jump");
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    m_sticky = 0;
    chk("clr_sticky", bus.err_sticky, 0);

    saved = m_count;
    for (int i = 0; i < 3; i++) apply(up_next(m_ab), 1'b0);
    bus.enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("reen_count", bus.count, saved);
    check_all("reen");

    // clr_err on the same edge as a fresh err: set must win
    nab = m_ab ^ 2'b11;
    bus.a_in = nab[1];
    bus.b_in = nab[0];
    model_move(nab, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_vs_set_sticky", bus.err_sticky, 1);
    check_all("clr_vs_set");

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        bus.data = 4'($urandom_range(0, 15));
        bus.load = 1'b1;
        m_count = int'(bus.data);
        @(posedge clk);
        #1;
        bus.load = 1'b0;
      end else if (r == 1) begin
        bus.clr_err = 1'b1;
        m_sticky = 0;
        @(posedge clk);
        #1;
        bus.clr_err = 1'b0;
      end else begin
        apply(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      end
      check_all("rand");
    end

    // reset mid-operation beats a simultaneous load
    bus.load = 1'b1;
    bus.data = 4'd9;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_over_load_count", bus.count, 0);
    chk("rst_over_load_sticky", bus.err_sticky, 0);
    bus.load = 1'b0;
    reset = 1'b0;
    chk("never_step_and_err", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature (A/B) decoder that turns two asynchronous encoder phase inputs into a signed-direction up/down position count.
- Synchronises the raw inputs, checks each transition against the Gray sequence, then counts up or down.
- Sits in front of the counter datapath and reuses the same enable/load/data/count control semantics, so position can be preset and frozen.

Parameters:
N, 4, width of position count (modulo 2^N).
SYNC_STAGES, 2, flip-flop stages in each input synchroniser (legal range 2 to 3).

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
enable  input  1  1 = decoded steps update count; 0 = count frozen.
a_in  input  1  encoder phase A, asynchronous to clk.
b_in  input  1  encoder phase B, asynchronous to clk.
load  input  1  1 = count <= data on this edge.
data  input  N  preset value for load.
clr_err  input  1  1 = clear err_sticky.
count  output  N  current position.
dir  output  1  direction of last accepted step (1 = up, 0 = down).
step  output  1  one-cycle pulse per accepted step.
err  output  1  one-cycle pulse on illegal transition.
err_sticky  output  1  set by err, held until clr_err or reset.

Behaviour:
Interface:
- One clock; reset is synchronous and active-high.
- Clock port is clk, reset port is reset.

Reset (reset=1 at a clk edge):
- count=0, dir=0, step=0, err=0, err_sticky=0.
- Synchroniser flops=0; FSM enters INIT.
- Reset asserted mid-operation overrides everything on that edge, including load.

Input path:
- a_in and b_in each pass through SYNC_STAGES flops. Synchronised pair is cur={a_s,b_s}; prev holds the last cur.

FSM:
- INIT: runs SYNC_STAGES+1 cycles after reset deasserts. prev <= cur every cycle; no decoding, no step/err. Then goes to RUN.
- RUN: every cycle, compare prev vs cur, then prev <= cur.
  - Up sequence (A leads B): 00->10->11->01->00 gives dir <= 1, count+1.
  - Down sequence: 00->01->11->10->00 gives dir <= 0, count-1.
  - cur == prev: no action.
  - Both bits changed (00<->11, 01<->10): err=1 for one cycle, err_sticky <= 1, count and dir unchanged.
- No spurious step after reset, whatever the idle input level.

Timing and arithmetic:
- Latency: an input change that meets setup at edge k is reflected in count/step/dir after edge k+SYNC_STAGES. With the default, that is 2 edges after capture.
- Count arithmetic is modulo 2^N: up from 2^N-1 wraps to 0, down from 0 wraps to 2^N-1. No saturation, no carry output.

Priority per edge: reset > load > decoded step.
- load=1: count <= data regardless of enable. A step decoded on the same edge is discarded (no step pulse), but dir still updates.
- err detection is independent of load.

enable=0:
- count holds; step and err are suppressed; dir and err_sticky hold.
- prev still tracks cur, so re-asserting enable never produces a catch-up step.

Other rules:
- clr_err=1 on the same edge as a new err: the set wins, err_sticky=1.
- step and err are never both 1.
- All outputs are registered.

Test Plan:
- Idle a_in=b_in=1, pulse reset 2 cycles, hold 12 cycles -> count=0, step never 1, err never 1.
- enable=1, drive 20 up transitions (A leads), 4 clk apart, from count=0 -> 20 step pulses, dir=1, count passes 15->0, final count=4.
- From count=4, drive 6 down transitions -> count sequence 3,2,1,0,15,14; dir=0; final count=14.
- load=1 with data=6 on the same edge a valid up step is decoded -> count=6, no step pulse that cycle; next up step gives count=7.
- Jump inputs 00->11 in one clk -> err pulse for exactly 1 cycle, err_sticky=1, count unchanged; clr_err=1 for 1 cycle -> err_sticky=0.
- enable=0, drive 3 up transitions, then enable=1 and hold inputs 10 cycles -> count unchanged, no step pulse during or after re-enable.
